dspl_fmt_counter: RTL and testbench

//  Upstream formatter for the 8-digit display driver. Converts a binary count (0..9999) to

---
 rtl/dspl_fmt_counter.sv | 192 +++++++++++++++++++
 tb/tb_dspl_fmt_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dspl_fmt_counter.sv
// Display formatter: binary count -> four BCD digits on d5..d8 with leading-zero blanking,
// status nibble on d1, optional whole-display blink.
module dspl_fmt_counter #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BLINK_MS = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [13:0] value,
    input  logic [3:0]  status,
    input  logic        status_en,
    input  logic        blink_en,
    output logic        busy,
    output logic        done,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);

    localparam int unsigned BIN_W    = 14;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SHIFTS   = 14;
    localparam int unsigned MAX_VAL  = 9999;
    localparam int unsigned TICK_CYC = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int unsigned PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned MS_W     = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    commit;
    logic [3:0][5:0]         st_q, st_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [MS_W-1:0]         ms_q, ms_d;
    logic                    phase_q, phase_d;
    logic                    tick;
    logic [3:0]              th, hu, te, un;
    logic                    en_th, en_hu, en_te;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Conversion FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        commit  = 1'b0;
        bcd_adj = dd_adj(bcd_q);
        case (state_q)
            IDLE: begin
                if (load) begin
                    ovf_d   = (value > BIN_W'(MAX_VAL));
                    bin_d   = ovf_d ? BIN_W'(MAX_VAL) : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SHIFTS - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit codes with leading-zero blanking; units digit always lit, its point flags saturation.
    always_comb begin
        th    = bcd_q[15:12];
        hu    = bcd_q[11:8];
        te    = bcd_q[7:4];
        un    = bcd_q[3:0];
        en_th = |th;
        en_hu = en_th | (|hu);
        en_te = en_hu | (|te);
        st_d  = st_q;
        if (commit) begin
            st_d[0] = {en_th, th, 1'b0};
            st_d[1] = {en_hu, hu, 1'b0};
            st_d[2] = {en_te, te, 1'b0};
            st_d[3] = {1'b1,  un, ovf_q};
        end
    end

    // Blink timing: ms prescaler then half-period counter; held idle while blink is off.
    always_comb begin
        pre_d   = pre_q;
        ms_d    = ms_q;
        phase_d = phase_q;
        tick    = 1'b0;
        if (!blink_en) begin
            pre_d   = '0;
            ms_d    = '0;
            phase_d = 1'b1;
        end else begin
            tick  = (pre_q == PRE_W'(TICK_CYC - 1));
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                if (ms_q == MS_W'(BLINK_MS - 1)) begin
                    ms_d    = '0;
                    phase_d = ~phase_q;
                end else begin
                    ms_d = ms_q + MS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            st_q    <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            phase_q <= 1'b1;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            st_q    <= st_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            phase_q <= phase_d;
        end
    end

    // Output registers use next-cycle phase so the enable mask lines up with the stored code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            d1   <= '0;
            d5   <= '0;
            d6   <= '0;
            d7   <= '0;
            d8   <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= commit;
            d1   <= {status_en & phase_d, status, 1'b0};
            d5   <= {st_d[0][5] & phase_d, st_d[0][4:0]};
            d6   <= {st_d[1][5] & phase_d, st_d[1][4:0]};
            d7   <= {st_d[2][5] & phase_d, st_d[2][4:0]};
            d8   <= {st_d[3][5] & phase_d, st_d[3][4:0]};
        end
    end

    assign d2 = 6'b0;
    assign d3 = 6'b0;
    assign d4 = 6'b0;

endmodule

// File: tb/tb_dspl_fmt_counter.sv
// Bench for dspl_fmt_counter: directed literal checks plus randomized traffic compared
// every cycle against an arithmetic model of the display contents.
module tb_dspl_fmt_counter;

    localparam int unsigned CLK_HZ    = 4000;
    localparam int unsigned BLINK_MS  = 2;
    localparam int          PHASE_CYC = (CLK_HZ / 1000) * BLINK_MS;

    logic        clock = 1'b0;
    logic        reset, load, status_en, blink_en;
    logic [13:0] value;
    logic [3:0]  status;
    logic        busy, done;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_on = 1'b0;

    dspl_fmt_counter #(.CLK_HZ(CLK_HZ), .BLINK_MS(BLINK_MS)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .status(status), .status_en(status_en), .blink_en(blink_en),
        .busy(busy), .done(done),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: remaining-cycle counter for the conversion, decimal digits by division,
    // blink phase from the count of consecutive enabled cycles.
    int         rem;
    int         pv;
    logic       povf;
    logic [5:0] m_st [4];
    logic [5:0] m_d1;
    logic       m_done;
    int         bc;
    logic       m_phase;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rem     <= 0;
            pv      <= 0;
            povf    <= 1'b0;
            m_done  <= 1'b0;
            m_d1    <= '0;
            bc      <= 0;
            m_phase <= 1'b1;
            for (int i = 0; i < 4; i++) m_st[i] <= '0;
        end else begin
            m_done <= 1'b0;
            if (rem == 0) begin
                if (load) begin
                    rem  <= 15;
                    povf <= (value > 14'd9999);
                    pv   <= (value > 14'd9999) ? 9999 : int'(value);
                end
            end else begin
                rem <= rem - 1;
                if (rem == 1) begin
                    m_done  <= 1'b1;
                    m_st[0] <= {(pv >= 1000), 4'(pv / 1000), 1'b0};
                    m_st[1] <= {(pv >= 100), 4'((pv / 100) % 10), 1'b0};
                    m_st[2] <= {(pv >= 10), 4'((pv / 10) % 10), 1'b0};
                    m_st[3] <= {1'b1, 4'(pv % 10), povf};
                end
            end
            m_d1    <= {status_en, status, 1'b0};
            bc      <= blink_en ? bc + 1 : 0;
            m_phase <= blink_en ? ((((bc + 1) / PHASE_CYC) % 2) == 0) : 1'b1;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check("busy", busy, (rem != 0));
            check("done", done, m_done);
            check("d1", d1, {m_d1[5] & m_phase, m_d1[4:0]});
            check("d2", d2, 6'h00);
            check("d3", d3, 6'h00);
            check("d4", d4, 6'h00);
            check("d5", d5, {m_st[0][5] & m_phase, m_st[0][4:0]});
            check("d6", d6, {m_st[1][5] & m_phase, m_st[1][4:0]});
            check("d7", d7, {m_st[2][5] & m_phase, m_st[2][4:0]});
            check("d8", d8, {m_st[3][5] & m_phase, m_st[3][4:0]});
        end
    end

    task automatic tick1();
        @(posedge clock);
        #1;
    endtask

    // Start a conversion and wait (bounded) for done; also measures busy length.
    task automatic do_conv(input logic [13:0] v);
        int  busy_n;
        logic seen;
        busy_n = 0;
        seen   = 1'b0;
        load   = 1'b1;
        value  = v;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick1();
            load = 1'b0;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        check("conv_done_seen", seen, 1'b1);
        check("conv_busy_len", busy_n, 15);
    endtask

    task automatic check_lo(input string name, input logic [5:0] e5, input logic [5:0] e6,
                            input logic [5:0] e7, input logic [5:0] e8);
        check({name, "_d5"}, d5, e5);
        check({name, "_d6"}, d6, e6);
        check({name, "_d7"}, d7, e7);
        check({name, "_d8"}, d8, e8);
    endtask

    initial begin
        int   done_n;
        logic seen;
        reset     = 1'b1;
        load      = 1'b0;
        value     = '0;
        status    = '0;
        status_en = 1'b0;
        blink_en  = 1'b0;
        repeat (3) tick1();
        reset  = 1'b0;
        chk_on = 1'b1;
        tick1();

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_d1", d1, 6'h00);
        check_lo("rst", 6'h00, 6'h00, 6'h00, 6'h00);

        do_conv(14'd1234);
        check_lo("v1234", 6'h22, 6'h24, 6'h26, 6'h28);
        do_conv(14'd7);
        check_lo("v7", 6'h00, 6'h00, 6'h00, 6'h2E);
        do_conv(14'd0);
        check_lo("v0", 6'h00, 6'h00, 6'h00, 6'h20);
        do_conv(14'd1005);
        check_lo("v1005", 6'h22, 6'h20, 6'h20, 6'h2A);
        do_conv(14'd12000);
        check_lo("v12000", 6'h32, 6'h32, 6'h32, 6'h33);
        do_conv(14'd50);
        check_lo("v50", 6'h00, 6'h00, 6'h2A, 6'h20);

        // Load while busy is dropped.
        load  = 1'b1;
        value = 14'd1234;
        tick1();
        load = 1'b0;
        repeat (4) tick1();
        load  = 1'b1;
        value = 14'd42;
        tick1();
        load = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick1();
            if (done) seen = 1'b1;
        end
        check("ign_done_seen", seen, 1'b1);
        check_lo("ign", 6'h22, 6'h24, 6'h26, 6'h28);
        tick1();

        // Reset mid-conversion abandons it.
        load  = 1'b1;
        value = 14'd4321;
        tick1();
        load = 1'b0;
        repeat (6) tick1();
        reset = 1'b1;
        tick1();
        check("abn_busy", busy, 1'b0);
        check("abn_done", done, 1'b0);
        check_lo("abn", 6'h00, 6'h00, 6'h00, 6'h00);
        reset  = 1'b0;
        done_n = 0;
        for (int c = 0; c < 20; c++) begin
            tick1();
            if (done) done_n++;
        end
        check("abn_no_done", done_n, 0);

        // Blink: 8 cycles on, 8 off with 4 cycles/ms and 2 ms half-period.
        do_conv(14'd7);
        status    = 4'hA;
        status_en = 1'b1;
        blink_en  = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick1();
            if (k == 7)  begin check("blk7_d1", d1, 6'h34); check("blk7_d8", d8, 6'h2E); end
            if (k == 8)  begin check("blk8_d1", d1, 6'h14); check("blk8_d8", d8, 6'h0E); end
            if (k == 15) check("blk15_d1", d1, 6'h14);
            if (k == 16) check("blk16_d1", d1, 6'h34);
            if (k == 26) check("blk26_d1", d1, 6'h14);
        end
        blink_en = 1'b0;
        tick1();
        check("blkoff_d1", d1, 6'h34);
        check("blkoff_d8", d8, 6'h2E);

        // Randomized traffic; the per-cycle compare process does the checking.
        repeat (3000) begin
            @(negedge clock);
            #1;
            reset = ($urandom_range(0, 499) == 0);
            load  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       value = 14'($urandom_range(0, 9));
                1:       value = 14'($urandom_range(9990, 16383));
                default: value = 14'($urandom_range(0, 16383));
            endcase
            status    = 4'($urandom);
            status_en = 1'($urandom);
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
